rf_wr_arb: RTL and testbench

RF_WR_ARB -- requirements
Module: rf_wr_arb

---
 rtl/rf_wr_arb.sv | 94 +++++++++
 tb/tb_rf_wr_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arb.sv
// rf_wr_arb: two-requester register-file write arbiter.
// Each requester feeds a 2-entry FIFO; heads are granted round-robin onto a registered write port.
module rf_wr_arb_fifo2 #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         ready,
    output logic [W-1:0] head,
    output logic         nonempty
);
    logic [W-1:0] mem [2];
    logic         wp, rp;
    logic [1:0]   cnt, cnt_nx;
    logic         push;

    assign push     = valid && ready;
    assign cnt_nx   = cnt + 2'(push) - 2'(pop);
    assign head     = mem[rp];
    assign nonempty = cnt != 2'd0;

    // ready is registered from the next occupancy so it never depends on valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            cnt   <= 2'd0;
            ready <= 1'b0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt   <= cnt_nx;
            ready <= cnt_nx != 2'd2;
        end
    end
endmodule

module rf_wr_arb #(
    parameter int AW = 2,
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          we0,
    output logic [AW-1:0] waddr0,
    output logic [DW-1:0] din0,
    output logic          idle
);
    logic [AW+DW-1:0] a_head, b_head;
    logic             a_ne, b_ne, grant_a, grant_b, ptr;

    rf_wr_arb_fifo2 #(.W(AW + DW)) u_fifo_a (
        .clk(clk), .rst_n(rst_n), .valid(a_valid), .pop(grant_a),
        .din({a_addr, a_data}), .ready(a_ready), .head(a_head), .nonempty(a_ne)
    );

    rf_wr_arb_fifo2 #(.W(AW + DW)) u_fifo_b (
        .clk(clk), .rst_n(rst_n), .valid(b_valid), .pop(grant_b),
        .din({b_addr, b_data}), .ready(b_ready), .head(b_head), .nonempty(b_ne)
    );

    // ptr=0 favours A; whichever port wins, priority moves to the other one
    assign grant_a = a_ne && (!b_ne || !ptr);
    assign grant_b = b_ne && (!a_ne || ptr);
    assign idle    = !a_ne && !b_ne && !we0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr    <= 1'b0;
            we0    <= 1'b0;
            waddr0 <= '0;
            din0   <= '0;
        end else begin
            we0 <= grant_a || grant_b;
            if (grant_a) ptr <= 1'b1;
            if (grant_b) ptr <= 1'b0;
            if (grant_a || grant_b) {waddr0, din0} <= grant_a ? a_head : b_head;
        end
    end
endmodule

// File: tb/tb_rf_wr_arb.sv
// tb_rf_wr_arb: scoreboard bench for rf_wr_arb; directed pushes queue hand-computed writes,
// a negedge monitor compares every we0 beat against the queue head.
module tb_rf_wr_arb;
    localparam int AW = 2;
    localparam int DW = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          we0, idle;
    logic [AW-1:0] waddr0;
    logic [DW-1:0] din0;

    int checks = 0;
    int errors = 0;
    int streak = 0;
    int max_streak = 0;
    logic [AW+DW-1:0] expq[$];
    logic [DW-1:0]    rf [4];

    rf_wr_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .we0(we0), .waddr0(waddr0), .din0(din0), .idle(idle)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we0 === 1'b1) begin
            logic [AW+DW-1:0] e;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", waddr0, din0);
            end else begin
                e = expq.pop_front();
                if ({waddr0, din0} !== e) begin
                    errors++;
                    $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                             waddr0, din0, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
            rf[waddr0] = din0;
            streak++;
            if (streak > max_streak) max_streak = streak;
        end else begin
            streak = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int ia, ib;
        logic ra, rb;
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        tick();
        tick();
        check("rst_we0", 32'(we0), 0);
        check("rst_waddr0", 32'(waddr0), 0);
        check("rst_din0", 32'(din0), 0);
        check("rst_a_ready", 32'(a_ready), 0);
        check("rst_b_ready", 32'(b_ready), 0);
        check("rst_idle", 32'(idle), 1);
        rst_n = 1'b1;
        tick();
        check("rel_a_ready", 32'(a_ready), 1);
        check("rel_b_ready", 32'(b_ready), 1);

        // single write
        expq.push_back({2'd2, 17'h1ABCD});
        a_valid = 1'b1; a_addr = 2'd2; a_data = 17'h1ABCD;
        tick();
        a_valid = 1'b0;
        check("single_not_early", 32'(we0), 0);
        check("single_busy", 32'(idle), 0);
        tick();
        check("single_we0", 32'(we0), 1);
        check("single_waddr0", 32'(waddr0), 2);
        check("single_din0", 32'(din0), 32'h1ABCD);
        tick();
        check("single_we0_drop", 32'(we0), 0);
        check("single_idle", 32'(idle), 1);
        check("hold_waddr0", 32'(waddr0), 2);
        check("hold_din0", 32'(din0), 32'h1ABCD);

        // contention after reset: A first, then B, same address
        do_reset();
        expq.push_back({2'd1, 17'h00001});
        expq.push_back({2'd1, 17'h00002});
        a_valid = 1'b1; a_addr = 2'd1; a_data = 17'h00001;
        b_valid = 1'b1; b_addr = 2'd1; b_data = 17'h00002;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        check("cont_first_din0", 32'(din0), 1);
        tick();
        check("cont_second_we0", 32'(we0), 1);
        check("cont_second_din0", 32'(din0), 2);
        tick();
        check("cont_rf1", 32'(rf[1]), 2);

        // streaming with backpressure: 8 beats each, alternating A,B from reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            expq.push_back({2'(i), 17'h100 + 17'(i)});
            expq.push_back({2'(i + 1), 17'h200 + 17'(i)});
        end
        max_streak = 0;
        ia = 0; ib = 0;
        for (int c = 0; c < 60 && (ia < 8 || ib < 8); c++) begin
            a_valid = ia < 8; a_addr = 2'(ia);     a_data = 17'h100 + 17'(ia);
            b_valid = ib < 8; b_addr = 2'(ib + 1); b_data = 17'h200 + 17'(ib);
            ra = a_ready; rb = b_ready;
            tick();
            if (a_valid && ra) ia++;
            if (b_valid && rb) ib++;
            if (c == 1) check("bp_b_ready_low", 32'(b_ready), 0);
            if (c == 2) check("full_a_ready_low", 32'(a_ready), 0);
            if (c == 3) check("full_pop_a_ready_back", 32'(a_ready), 1);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("stream_a_accepted", 32'(ia), 8);
        check("stream_b_accepted", 32'(ib), 8);
        for (int i = 0; i < 5; i++) tick();
        check("stream_streak", 32'(max_streak), 16);
        check("stream_idle", 32'(idle), 1);

        // reset mid-stream
        do_reset();
        expq.push_back({2'd0, 17'h300});
        a_valid = 1'b1; a_addr = 2'd0; a_data = 17'h300;
        b_valid = 1'b1; b_addr = 2'd1; b_data = 17'h400;
        tick();
        a_data = 17'h301; b_data = 17'h401;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("mid_pre_we0", 32'(we0), 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_we0", 32'(we0), 0);
        check("mid_rst_idle", 32'(idle), 1);
        check("mid_rst_a_ready", 32'(a_ready), 0);
        check("mid_rst_b_ready", 32'(b_ready), 0);
        rst_n = 1'b1;
        tick();
        check("mid_rel_a_ready", 32'(a_ready), 1);
        expq.push_back({2'd3, 17'h1FFFF});
        a_valid = 1'b1; a_addr = 2'd3; a_data = 17'h1FFFF;
        tick();
        a_valid = 1'b0;
        check("mid_new_not_early", 32'(we0), 0);
        tick();
        check("mid_new_we0", 32'(we0), 1);
        check("mid_new_din0", 32'(din0), 32'h1FFFF);
        for (int i = 0; i < 3; i++) tick();
        check("scoreboard_drained", 32'(expq.size()), 0);
        check("final_idle", 32'(idle), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
